// File: rtl/mult_share_arbiter_if.sv
// Bundles the requester, multiplier and response channels of mult_share_arbiter.
// The arbiter uses the slave modport; the requester/multiplier/consumer side uses master.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           mult_a;
  logic [31:0]           mult_b;
  logic [63:0]           mult_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_result;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, mult_result, rsp_ready,
    input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mult_result, rsp_ready,
    output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external combinational 32x32 multiplier among NUM_REQ
// requesters: grant, register operands, wait MULT_LATENCY cycles, return tagged product.
module mult_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MULT_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [63:0]     rsp_result_q, rsp_result_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] grant_oh;

  // Cyclic search starting just after the last served requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      rsp_id_q     <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d  = bus.req_a[int'(grant_idx)*32 +: 32];
          op_b_d  = bus.req_b[int'(grant_idx)*32 +: 32];
          id_d    = grant_idx;
          ptr_d   = grant_idx;
          cnt_d   = 4'(MULT_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The product is sampled once the settling window has fully elapsed.
        if (cnt_q == 4'd0) begin
          rsp_result_d = bus.mult_result;
          rsp_id_d     = id_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found) begin
      grant_oh[grant_idx] = 1'b1;
    end
    bus.req_ready  = (rst_n && state_q == IDLE) ? grant_oh : '0;
    bus.mult_a     = op_a_q;
    bus.mult_b     = op_b_q;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_id     = rsp_id_q;
    bus.rsp_result = rsp_result_q;
    bus.busy       = (state_q != IDLE);
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one combinational signed 32x32 multiplier among NUM_REQ requesters. It arbitrates requests and registers the granted operands onto the multiplier inputs. It waits a fixed multicycle settling window, then captures the 64-bit product and returns it on a single tagged response channel. One operation is in flight at a time; the multiplier instance sits outside this block and connects through the mult_* ports.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, 2: requester-ID width; must equal ceil(log2(NUM_REQ)).
- MULT_LATENCY, 2: cycles allowed for the multiplier to settle; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit set.
- req_a  in  NUM_REQ*32  operand A; requester i uses slice [32i+31:32i], two's complement.
- req_b  in  NUM_REQ*32  operand B; same slicing as req_a.
- mult_a  out  32  registered operand A to the multiplier.
- mult_b  out  32  registered operand B to the multiplier.
- mult_result  in  64  signed product from the multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns rsp_result.
- rsp_result  out  64  captured signed product.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - grant g is the first index with req_valid set, searching cyclically from ptr+1.
  - req_ready = one-hot(g) if any req_valid is set, else 0.
  - On the handshake: op_a<=req_a[g], op_b<=req_b[g], id<=g, ptr<=g, cnt<=MULT_LATENCY-1, state goes to WAIT.
- WAIT:
  - req_ready=0. mult_a and mult_b stay stable.
  - If cnt==0: rsp_result<=mult_result, rsp_id<=id, state goes to RESP. Otherwise cnt decrements.
- RESP:
  - rsp_valid=1. rsp_id and rsp_result are held stable.
  - On rsp_valid&&rsp_ready the state goes to IDLE. rsp_valid stays high until that handshake.
- Arithmetic: the block passes operand bits unchanged and performs no arithmetic on data. The signed interpretation belongs to the multiplier; the block does no sign extension or truncation.
- Requester rules:
  - req_valid and operands hold until req_ready.
  - A requester that drops req_valid before its grant is simply not selected; no error is raised.
- Fairness: after requester i is served, every other requester with valid held is served before i again. Worst-case wait is NUM_REQ-1 operations.
- Reset (any cycle, including mid-operation):
  - state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), cnt=0.
  - In-flight operation is discarded.
  - Outputs: req_ready=0, mult_a=0, mult_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - req_ready is forced 0 while rst_n=0.

## Timing
- Request handshake in cycle T gives mult_a/mult_b valid from T+1.
- Product captured at the end of T+MULT_LATENCY; rsp_valid first high in T+MULT_LATENCY+1.
- Response handshake in cycle R puts the FSM in IDLE at R+1; the earliest next req_ready is R+1.
- Throughput with rsp_ready tied high: one operation per MULT_LATENCY+2 cycles.
- req_ready is combinational from req_valid, state and ptr, with no combinational path from rsp_ready.
- A new req_valid that rises while busy is ignored until IDLE and then arbitrated normally.
- When a request and a response complete in the same cycle, that cycle is in RESP only. No request is accepted until the following IDLE cycle.

## Test plan
- Reset, then a single requester:
  - stimulus: req 0 with a=0xFFFFFFFF (-1), b=0xFFFFFFFF, MULT_LATENCY=2.
  - required: req_ready[0] in T; rsp_valid at T+3 with rsp_id=0, rsp_result=0x0000000000000001.
- Corner operands:
  - stimulus: 0x80000000*0x80000000, then 0x7FFFFFFF*0x80000000.
  - required: results 0x4000000000000000, then 0xC000000080000000.
- Round-robin:
  - stimulus: all 4 req_valid held high from reset with distinct operands.
  - required: grant order 0,1,2,3,0.
  - required: every rsp_id matches its product from a bench reference model.
- Backpressure:
  - stimulus: rsp_ready low for 5 cycles during RESP.
  - required: rsp_valid, rsp_id and rsp_result stay constant; all req_ready stay 0; the next grant is the cycle after the handshake.
- Mid-operation reset:
  - stimulus: rst_n low for 1 cycle during WAIT.
  - required: next cycle all outputs 0 and busy=0; the in-flight response is never issued; requester 0 has priority afterwards.
- Latency sweep:
  - stimulus: MULT_LATENCY=1 and MULT_LATENCY=15 with rsp_ready high.
  - required: rsp_valid exactly MULT_LATENCY+1 cycles after the request handshake; back-to-back period is MULT_LATENCY+2.
